// File: rtl/vc_allocator.sv
// vc_allocator
//   Hands out free downstream virtual channels to upstream VCs that hold a
//   head flit. Each output port grants at most one requester per cycle,
//   chosen round-robin over the flat upstream index (up_port*VC_NUM+up_vc).
//   Ownership of a downstream VC lasts from its grant until its tail-flit
//   release. The granted VC index later feeds the switch allocator.
//
// Ports
//   clk             clock
//   rst             asynchronous active-high reset
//   request_i       [PORT_NUM][VC_NUM]  upstream VC wants a downstream VC
//   out_port_i      [PORT_NUM][VC_NUM]  requested output port per upstream VC
//   release_i       [PORT_NUM][VC_NUM]  pulse: downstream VC [out][vc] freed
//   grant_o         [PORT_NUM][VC_NUM]  one-cycle pulse: upstream VC granted
//   grant_vc_o      [PORT_NUM][VC_NUM]  allocated downstream VC index
//   is_available_o  [PORT_NUM][VC_NUM]  free state of each downstream VC
module vc_allocator #(
  parameter int PORT_NUM  = 5,
  parameter int VC_NUM    = 2,
  parameter int PORT_SIZE = $clog2(PORT_NUM),
  parameter int VC_SIZE   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]               request_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0] out_port_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]               release_i,
  output logic [PORT_NUM-1:0][VC_NUM-1:0]               grant_o,
  output logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]   grant_vc_o,
  output logic [PORT_NUM-1:0][VC_NUM-1:0]               is_available_o
);

  localparam int FLAT  = PORT_NUM * VC_NUM;
  localparam int PTR_W = (FLAT > 1) ? $clog2(FLAT) : 1;
  localparam logic [PORT_SIZE:0] PORT_LIMIT = (PORT_SIZE + 1)'(PORT_NUM);

  logic [PORT_NUM-1:0][VC_NUM-1:0]               avail;
  logic [PORT_NUM-1:0][PTR_W-1:0]                rr_ptr;
  logic [PORT_NUM-1:0][VC_NUM-1:0]               eff_req;
  logic [PORT_NUM-1:0][FLAT-1:0]                 cand;
  logic [PORT_NUM-1:0]                           cand_found;
  logic [PORT_NUM-1:0][PTR_W-1:0]                win_idx;
  logic [PORT_NUM-1:0]                           free_found;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]              free_vc;
  logic [PORT_NUM-1:0]                           win_valid;
  logic [PORT_NUM-1:0][VC_NUM-1:0]               grant_next;
  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]  grant_vc_next;
  logic [PORT_NUM-1:0][VC_NUM-1:0]               alloc;

  assign is_available_o = avail;

  // Qualify requests and sort them by requested output port. A VC granted
  // last cycle is masked so it cannot win twice before the input block
  // drops its request; out-of-range port indices never become candidates.
  always_comb begin
    eff_req = '0;
    cand    = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        eff_req[p][v] = request_i[p][v] & ~grant_o[p][v] &
                        ({1'b0, out_port_i[p][v]} < PORT_LIMIT);
        for (int o = 0; o < PORT_NUM; o++) begin
          if (eff_req[p][v] && (out_port_i[p][v] == PORT_SIZE'(o)))
            cand[o][p*VC_NUM+v] = 1'b1;
        end
      end
    end
  end

  // Per output port: pick the lowest free downstream VC and the first
  // candidate after the last winner. Both scans run from the far end back
  // toward the preferred entry, so the last hit written is the preferred one.
  always_comb begin
    cand_found = '0;
    win_idx    = '0;
    free_found = '0;
    free_vc    = '0;
    win_valid  = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int v = VC_NUM - 1; v >= 0; v--) begin
        if (avail[o][v]) begin
          free_found[o] = 1'b1;
          free_vc[o]    = VC_SIZE'(v);
        end
      end
      for (int k = FLAT; k >= 1; k--) begin
        if (cand[o][(int'(rr_ptr[o]) + k) % FLAT]) begin
          cand_found[o] = 1'b1;
          win_idx[o]    = PTR_W'((int'(rr_ptr[o]) + k) % FLAT);
        end
      end
      win_valid[o] = cand_found[o] & free_found[o];
    end
  end

  // Turn per-output winners into per-upstream grant bits and per-downstream
  // allocation bits. An upstream VC targets one port, so at most one output
  // can name it as winner.
  always_comb begin
    grant_next    = '0;
    grant_vc_next = '0;
    alloc         = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      if (win_valid[o])
        alloc[o][free_vc[o]] = 1'b1;
    end
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        for (int o = 0; o < PORT_NUM; o++) begin
          if (win_valid[o] && (win_idx[o] == PTR_W'(p*VC_NUM+v))) begin
            grant_next[p][v]    = 1'b1;
            grant_vc_next[p][v] = free_vc[o];
          end
        end
      end
    end
  end

  // State update. Releases are OR-ed in after allocation so a release wins
  // if both ever hit the same VC. Pointers start at the last flat index so
  // flat index 0 has first priority out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avail      <= '1;
      rr_ptr     <= {PORT_NUM{PTR_W'(FLAT - 1)}};
      grant_o    <= '0;
      grant_vc_o <= '0;
    end else begin
      avail      <= (avail & ~alloc) | release_i;
      grant_o    <= grant_next;
      grant_vc_o <= grant_vc_next;
      for (int o = 0; o < PORT_NUM; o++) begin
        if (win_valid[o])
          rr_ptr[o] <= win_idx[o];
      end
    end
  end

endmodule

// File: tb/tb_vc_allocator.sv
// tb_vc_allocator
//   Directed bench for vc_allocator (PORT_NUM=5, VC_NUM=2). Flat bit p*2+v of
//   each 10-bit vector is upstream/downstream VC [p][v]; grant_vc_o is one
//   bit per upstream VC because VC_SIZE is 1.
module tb_vc_allocator;

  logic                  clk;
  logic                  rst;
  logic [4:0][1:0]       request_v;
  logic [4:0][1:0][2:0]  out_port_v;
  logic [4:0][1:0]       release_v;
  logic [4:0][1:0]       grant_v;
  logic [4:0][1:0][0:0]  grant_vc_v;
  logic [4:0][1:0]       avail_v;

  int test_count;
  int fail_count;

  vc_allocator #(.PORT_NUM(5), .VC_NUM(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .request_i      (request_v),
    .out_port_i     (out_port_v),
    .release_i      (release_v),
    .grant_o        (grant_v),
    .grant_vc_o     (grant_vc_v),
    .is_available_o (avail_v)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive request/release vectors, then move to 1 unit after the next edge.
  task automatic applyStimulus(input logic [9:0] req, input logic [9:0] rel);
    request_v = req;
    release_v = rel;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    test_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Check grant, granted VC index and availability in one call.
  task automatic checkAll(input string tag, input logic [9:0] g,
                          input logic [9:0] gvc, input logic [9:0] av);
    checkOutput({tag, ".grant"}, 32'(grant_v), 32'(g));
    checkOutput({tag, ".grant_vc"}, 32'(grant_vc_v), 32'(gvc));
    checkOutput({tag, ".avail"}, 32'(avail_v), 32'(av));
  endtask

  initial begin
    test_count = 0;
    fail_count = 0;
    rst        = 1'b1;
    request_v  = '0;
    release_v  = '0;
    out_port_v = '0;

    // Reset state
    applyStimulus(10'h000, 10'h000);
    applyStimulus(10'h000, 10'h000);
    checkAll("reset", 10'h000, 10'h000, 10'h3FF);
    rst = 1'b0;

    // Single request [0][0] -> port 2
    out_port_v[0][0] = 3'd2;
    applyStimulus(10'h001, 10'h000);
    checkAll("single.grant", 10'h001, 10'h000, 10'h3EF);
    applyStimulus(10'h000, 10'h000);
    checkAll("single.pulse", 10'h000, 10'h000, 10'h3EF);
    applyStimulus(10'h000, 10'h010);
    checkAll("single.release", 10'h000, 10'h000, 10'h3FF);

    // Round robin on port 1: [1][0] flat2, [3][1] flat7, [4][0] flat8
    out_port_v = '0;
    out_port_v[1][0] = 3'd1;
    out_port_v[3][1] = 3'd1;
    out_port_v[4][0] = 3'd1;
    applyStimulus(10'h184, 10'h000);
    checkAll("rr.1", 10'h004, 10'h000, 10'h3FB);
    applyStimulus(10'h184, 10'h004);
    checkAll("rr.2", 10'h080, 10'h080, 10'h3F7);
    applyStimulus(10'h184, 10'h008);
    checkAll("rr.3", 10'h100, 10'h000, 10'h3FB);
    applyStimulus(10'h184, 10'h004);
    checkAll("rr.4wrap", 10'h004, 10'h004, 10'h3F7);
    applyStimulus(10'h000, 10'h008);
    checkAll("rr.done", 10'h000, 10'h000, 10'h3FF);

    // Fill port 3, then a held request waits for a release
    out_port_v = '0;
    out_port_v[0][0] = 3'd3;
    out_port_v[0][1] = 3'd3;
    out_port_v[2][0] = 3'd3;
    applyStimulus(10'h003, 10'h000);
    checkAll("full.a", 10'h001, 10'h000, 10'h3BF);
    applyStimulus(10'h002, 10'h000);
    checkAll("full.b", 10'h002, 10'h002, 10'h33F);
    applyStimulus(10'h010, 10'h000);
    checkAll("full.wait1", 10'h000, 10'h000, 10'h33F);
    applyStimulus(10'h010, 10'h000);
    checkAll("full.wait2", 10'h000, 10'h000, 10'h33F);
    applyStimulus(10'h010, 10'h080);
    checkAll("full.relE", 10'h000, 10'h000, 10'h3BF);
    applyStimulus(10'h010, 10'h000);
    checkAll("full.regrant", 10'h010, 10'h010, 10'h33F);
    applyStimulus(10'h000, 10'h0C0);
    checkAll("full.clean", 10'h000, 10'h000, 10'h3FF);

    // Two outputs grant in the same cycle
    out_port_v = '0;
    out_port_v[0][0] = 3'd1;
    out_port_v[2][1] = 3'd4;
    applyStimulus(10'h021, 10'h000);
    checkAll("dual", 10'h021, 10'h000, 10'h2FB);
    applyStimulus(10'h000, 10'h104);
    checkAll("dual.clean", 10'h000, 10'h000, 10'h3FF);

    // Out-of-range port is ignored; releasing a free VC changes nothing
    out_port_v = '0;
    out_port_v[0][0] = 3'd7;
    applyStimulus(10'h001, 10'h000);
    checkAll("oor.1", 10'h000, 10'h000, 10'h3FF);
    applyStimulus(10'h001, 10'h000);
    checkAll("oor.2", 10'h000, 10'h000, 10'h3FF);
    applyStimulus(10'h000, 10'h001);
    checkAll("free.release", 10'h000, 10'h000, 10'h3FF);

    // Four grants at once, then asynchronous reset while they are visible
    out_port_v = '0;
    out_port_v[0][0] = 3'd0;
    out_port_v[0][1] = 3'd1;
    out_port_v[1][0] = 3'd2;
    out_port_v[1][1] = 3'd3;
    applyStimulus(10'h00F, 10'h000);
    checkAll("four", 10'h00F, 10'h000, 10'h3AA);
    rst = 1'b1;
    #1;
    checkAll("async.rst", 10'h000, 10'h000, 10'h3FF);
    out_port_v = '0;
    applyStimulus(10'h000, 10'h000);
    rst = 1'b0;

    // After reset flat 0 beats flat 5 on port 0
    out_port_v[0][0] = 3'd0;
    out_port_v[2][1] = 3'd0;
    applyStimulus(10'h021, 10'h000);
    checkAll("post.first", 10'h001, 10'h000, 10'h3FE);
    applyStimulus(10'h020, 10'h000);
    checkAll("post.second", 10'h020, 10'h020, 10'h3FC);
    applyStimulus(10'h000, 10'h000);
    checkAll("post.idle", 10'h000, 10'h000, 10'h3FC);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
